matrix_frame_parser: RTL

- Sits between the UART receiver and the A×B matrix-multiply core, upstream of the multiplier.
- Consumes the received byte stream and decodes a framed matrix load: sync byte, dimensions M/N/P, matrix A and matrix B in row-major order, and an XOR checksum.
- Drives write ports into the A/B operand memories and reports frame completion or a coded error to the multiply FSM.

---
 rtl/matrix_pkg.sv | 45 ++++
 rtl/matrix_frame_parser_if.sv | 36 +++
 rtl/matrix_index_counter.sv | 58 +++++
 rtl/matrix_frame_parser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix load/multiply path: sync byte, parser
// state encoding, error codes, default matrix limits and small helpers.
package matrix_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam int DEF_MAX_M  = 4;
    localparam int DEF_MAX_N  = 4;
    localparam int DEF_MAX_P  = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_M  = 3'd1,
        ST_HDR_N  = 3'd2,
        ST_HDR_P  = 3'd3,
        ST_LOAD_A = 3'd4,
        ST_LOAD_B = 3'd5,
        ST_CHECK  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_DIM     = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_code_t;

    // Larger of two integers, used for sizing shared index ports.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A header dimension is legal when it lies in 1..max_v.
    function automatic logic dim_ok(input logic [7:0] v, input int max_v);
        return (v != 8'd0) && (int'(v) <= max_v);
    endfunction

endpackage

// File: rtl/matrix_frame_parser_if.sv
// Byte-stream input, operand-memory write port and frame status of the
// matrix frame parser. The parser takes the master side, the UART/memory/
// multiply-FSM environment the slave side.
interface matrix_frame_parser_if import matrix_pkg::*; #(
    parameter int ROW_W  = idx_w(max2(DEF_MAX_M, DEF_MAX_N)),
    parameter int COL_W  = idx_w(max2(DEF_MAX_N, DEF_MAX_P)),
    parameter int DATA_W = DEF_DATA_W
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              core_busy;
    logic              wr_en;
    logic              wr_sel;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        dim_m;
    logic [2:0]        dim_n;
    logic [2:0]        dim_p;
    logic              frame_done;
    logic              frame_err;
    err_code_t         err_code;
    logic              busy;

    modport master (
        input  byte_in, byte_valid, core_busy,
        output wr_en, wr_sel, wr_row, wr_col, wr_data,
        output dim_m, dim_n, dim_p, frame_done, frame_err, err_code, busy
    );

    modport slave (
        output byte_in, byte_valid, core_busy,
        input  wr_en, wr_sel, wr_row, wr_col, wr_data,
        input  dim_m, dim_n, dim_p, frame_done, frame_err, err_code, busy
    );
endinterface

// File: rtl/matrix_index_counter.sv
// Row-major row/column walker with programmable limits. The column advances
// first; the last element wraps both indices back to zero so the same
// counter can immediately walk the next matrix.
module matrix_index_counter #(
    parameter int ROW_W = 2,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [COL_W-1:0] col_last_i,
    input  logic [ROW_W-1:0] row_last_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (col_q == col_last_i) && (row_q == row_last_i);

    // Next index: clear wins, otherwise step column then row on increment.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = {ROW_W{1'b0}};
            col_d = {COL_W{1'b0}};
        end else if (inc_i) begin
            if (col_q == col_last_i) begin
                col_d = {COL_W{1'b0}};
                if (row_q == row_last_i) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            row_d = row_q;
        end
    end

    // Index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= {ROW_W{1'b0}};
            col_q <= {COL_W{1'b0}};
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/matrix_frame_parser.sv
// Decodes a framed matrix load (sync, M/N/P, A, B, XOR checksum) from the
// UART byte stream and writes the operands into the A/B memories.
// Optional macro FRAME_TIMEOUT_EN adds an inter-byte gap timeout.
module matrix_frame_parser import matrix_pkg::*; #(
    parameter int MAX_M          = DEF_MAX_M,
    parameter int MAX_N          = DEF_MAX_N,
    parameter int MAX_P          = DEF_MAX_P,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_frame_parser_if.master bus
);
    localparam int ROW_W = idx_w(max2(MAX_M, MAX_N));
    localparam int COL_W = idx_w(max2(MAX_N, MAX_P));

    state_t            state_q, state_d;
    logic [7:0]        csum_q, csum_d;
    logic [2:0]        dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_p_q, dim_p_d;
    logic              wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
    logic [ROW_W-1:0]  wr_row_q, wr_row_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d, err_q, err_d, busy_q, busy_d;
    err_code_t         err_code_q, err_code_d;

    logic              cnt_clear_s, cnt_inc_s, cnt_last_s, timeout_s;
    logic [ROW_W-1:0]  cnt_row_s, row_last_s;
    logic [COL_W-1:0]  cnt_col_s, col_last_s;

    matrix_index_counter #(.ROW_W(ROW_W), .COL_W(COL_W)) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear_s),
        .inc_i      (cnt_inc_s),
        .col_last_i (col_last_s),
        .row_last_i (row_last_s),
        .row_o      (cnt_row_s),
        .col_o      (cnt_col_s),
        .last_o     (cnt_last_s)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    logic [GAP_W-1:0] gap_q;

    // Gap counter: idle-only hold at zero, reloaded by every received byte.
    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_IDLE) || bus.byte_valid) begin
            gap_q <= {GAP_W{1'b0}};
        end else begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end
    assign timeout_s = (state_q != ST_IDLE) && (gap_q == GAP_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Walk limits: A is M x N, B is N x P.
    always_comb begin
        if (state_q == ST_LOAD_B) begin
            col_last_s = COL_W'(dim_p_q - 3'd1);
            row_last_s = ROW_W'(dim_n_q - 3'd1);
        end else begin
            col_last_s = COL_W'(dim_n_q - 3'd1);
            row_last_s = ROW_W'(dim_m_q - 3'd1);
        end
    end

    // Frame FSM next state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        csum_d      = csum_q;
        dim_m_d     = dim_m_q;
        dim_n_d     = dim_n_q;
        dim_p_d     = dim_p_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        cnt_clear_s = 1'b0;
        cnt_inc_s   = 1'b0;

        if ((state_q != ST_IDLE) && bus.byte_valid && bus.core_busy) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_OVERRUN;
        end else if (bus.byte_valid && !bus.core_busy) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.byte_in == SYNC_BYTE) begin
                        csum_d      = 8'h00;
                        cnt_clear_s = 1'b1;
                        state_d     = ST_HDR_M;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HDR_M: begin
                    if (dim_ok(bus.byte_in, MAX_M)) begin
                        dim_m_d = bus.byte_in[2:0];
                        csum_d  = csum_q ^ bus.byte_in;
                        state_d = ST_HDR_N;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_DIM;
                    end
                end
                ST_HDR_N: begin
                    if (dim_ok(bus.byte_in, MAX_N)) begin
                        dim_n_d = bus.byte_in[2:0];
                        csum_d  = csum_q ^ bus.byte_in;
                        state_d = ST_HDR_P;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_DIM;
                    end
                end
                ST_HDR_P: begin
                    if (dim_ok(bus.byte_in, MAX_P)) begin
                        dim_p_d = bus.byte_in[2:0];
                        csum_d  = csum_q ^ bus.byte_in;
                        state_d = ST_LOAD_A;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_DIM;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == ST_LOAD_B);
                    wr_row_d  = cnt_row_s;
                    wr_col_d  = cnt_col_s;
                    wr_data_d = DATA_W'(bus.byte_in);
                    csum_d    = csum_q ^ bus.byte_in;
                    cnt_inc_s = 1'b1;
                    if (cnt_last_s) begin
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_CHECK;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (bus.byte_in == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_s) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            csum_q     <= 8'h00;
            dim_m_q    <= 3'd0;
            dim_n_q    <= 3'd0;
            dim_p_q    <= 3'd0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_row_q   <= {ROW_W{1'b0}};
            wr_col_q   <= {COL_W{1'b0}};
            wr_data_q  <= {DATA_W{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            csum_q     <= csum_d;
            dim_m_q    <= dim_m_d;
            dim_n_q    <= dim_n_d;
            dim_p_q    <= dim_p_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_sel     = wr_sel_q;
    assign bus.wr_row     = wr_row_q;
    assign bus.wr_col     = wr_col_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.dim_m      = dim_m_q;
    assign bus.dim_n      = dim_n_q;
    assign bus.dim_p      = dim_p_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = busy_q;
endmodule
